// File: rtl/calc_op_sequencer.sv
// Purpose : shared signed ADD/SUB/MUL/DIV engine with valid/ready request and response ports.
// Latency : ADD/SUB and divide-by-zero respond in 1 cycle; MUL/DIV respond in WIDTH+2 cycles.
// Backpr. : one operation in flight; req_ready is low until the response is taken, and the next accept is no earlier than the following cycle.
//
// Ports:
//   clk_in, rst                  clock; synchronous active-high reset
//   req_valid/req_ready          request handshake carrying req_op (00 ADD, 01 SUB, 10 MUL, 11 DIV), req_a, req_b
//   rsp_valid/rsp_ready          response handshake carrying rsp_result (2*WIDTH+1 bits signed) and rsp_div_zero
//   busy                         high whenever the sequencer is not idle
//   abort                        present only when CALC_SEQ_ABORT_EN is defined; drops the in-flight op
//
// Optional feature macro: CALC_SEQ_ABORT_EN

module calc_op_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst,
`ifdef CALC_SEQ_ABORT_EN
    input  logic                     abort,
`endif
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic signed [WIDTH-1:0]  req_a,
    input  logic signed [WIDTH-1:0]  req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic signed [2*WIDTH:0]  rsp_result,
    output logic                     rsp_div_zero,
    output logic                     busy
);

    localparam int RW = 2 * WIDTH + 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    // MUL: {partial product high, multiplier shifting out}.
    // DIV: {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     bmag_q, bmag_d;   // multiplicand or divisor magnitude
    logic                 mul_q, mul_d;
    logic                 neg_q, neg_d;
    logic [RW-1:0]        result_q, result_d;
    logic                 dz_q, dz_d;

    // Operand magnitudes; |-2^(WIDTH-1)| still fits as an unsigned WIDTH-bit value.
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [RW-1:0]        a_ext, b_ext;

    assign a_mag = req_a[WIDTH-1] ? (~req_a + 1'b1) : req_a;
    assign b_mag = req_b[WIDTH-1] ? (~req_b + 1'b1) : req_b;
    assign a_ext = {{(RW-WIDTH){req_a[WIDTH-1]}}, req_a};
    assign b_ext = {{(RW-WIDTH){req_b[WIDTH-1]}}, req_b};

    // Shift-add multiply step: conditionally add the multiplicand into the
    // upper half, then shift the whole accumulator right by one.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, bmag_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step: shift the next dividend bit into the remainder,
    // subtract the divisor when it fits, and shift the quotient bit in at the bottom.
    // When the subtraction is taken the difference is below the divisor, so it
    // always fits in WIDTH bits.
    logic [WIDTH:0]       rem_sh;
    logic                 div_ge;
    logic [WIDTH-1:0]     rem_nx;
    logic [2*WIDTH-1:0]   div_next;

    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge   = (rem_sh >= {1'b0, bmag_q});
    assign rem_nx   = div_ge ? (rem_sh[WIDTH-1:0] - bmag_q) : rem_sh[WIDTH-1:0];
    assign div_next = {rem_nx, acc_q[WIDTH-2:0], div_ge};

    // Final magnitude: full product for MUL, quotient in the low half for DIV.
    logic [RW-1:0]        mag_ext;

    assign mag_ext = mul_q ? {1'b0, acc_q} : {{(WIDTH+1){1'b0}}, acc_q[WIDTH-1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        bmag_d   = bmag_q;
        mul_d    = mul_q;
        neg_d    = neg_q;
        result_d = result_q;
        dz_d     = dz_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_ADD: begin
                            result_d = a_ext + b_ext;
                            dz_d     = 1'b0;
                            state_d  = S_DONE;
                        end
                        OP_SUB: begin
                            result_d = a_ext - b_ext;
                            dz_d     = 1'b0;
                            state_d  = S_DONE;
                        end
                        default: begin
                            if (req_op == OP_DIV && req_b == '0) begin
                                result_d = '0;
                                dz_d     = 1'b1;
                                state_d  = S_DONE;
                            end else begin
                                // Same load for both: low half holds |a| (multiplier
                                // or dividend), upper half starts at zero.
                                mul_d   = (req_op == OP_MUL);
                                neg_d   = req_a[WIDTH-1] ^ req_b[WIDTH-1];
                                bmag_d  = b_mag;
                                acc_d   = {{WIDTH{1'b0}}, a_mag};
                                cnt_d   = CW'(WIDTH - 1);
                                dz_d    = 1'b0;
                                state_d = S_ITER;
                            end
                        end
                    endcase
                end
            end

            S_ITER: begin
`ifdef CALC_SEQ_ABORT_EN
                if (abort) begin
                    state_d = S_IDLE;
                end else
`endif
                begin
                    acc_d = mul_q ? mul_next : div_next;
                    if (cnt_q == '0) begin
                        state_d = S_FIXUP;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            S_FIXUP: begin
`ifdef CALC_SEQ_ABORT_EN
                if (abort) begin
                    state_d = S_IDLE;
                end else
`endif
                begin
                    // Negating a zero magnitude yields zero, so no special case is needed.
                    result_d = neg_q ? (RW'(0) - mag_ext) : mag_ext;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
`ifdef CALC_SEQ_ABORT_EN
                if (abort) begin
                    dz_d    = 1'b0;
                    state_d = S_IDLE;
                end else
`endif
                if (rsp_ready) begin
                    dz_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            bmag_q   <= '0;
            mul_q    <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            bmag_q   <= bmag_d;
            mul_q    <= mul_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            dz_q     <= dz_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign rsp_result   = result_q;
    assign rsp_div_zero = dz_q;

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Shared arithmetic engine controller for the calculator.
- Accepts one signed operation request (a, b, op) over a valid/ready handshake.
- ADD/SUB complete in one cycle; MUL and DIV are sequenced over an iterative shift-add multiplier / restoring divider.
- Returns a signed result over a valid/ready handshake. Sits between the button/switch front-end FSM and the display path (binary-to-BCD), replacing single-cycle combinational `*` and `/` so the design meets timing at 100 MHz.

Parameters:
- WIDTH, 16, operand width in bits (signed two's complement); result width is 2*WIDTH+1.

Ports:
- clk_in  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- req_a  input  WIDTH  signed operand a
- req_b  input  WIDTH  signed operand b
- rsp_valid  output  1  result present
- rsp_ready  input  1  consumer takes result
- rsp_result  output  2*WIDTH+1  signed result
- rsp_div_zero  output  1  DIV with b==0 occurred (qualified by rsp_valid)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_div_zero=0, busy=0, iteration counter=0. Reset overrides every other input in the same cycle.
- States:
  - IDLE: req_ready=1. Accept when req_valid && req_ready on the clock edge, capturing op, a and b.
    - ADD/SUB: result written at the accept edge, sign-extended to 2*WIDTH+1; next state DONE.
    - DIV with b==0: rsp_result=0, rsp_div_zero=1; next state DONE.
    - MUL/DIV otherwise: load |a| and |b|, record the result sign, counter=WIDTH-1; next state ITER.
  - ITER: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle. Exit to FIXUP after the step with counter==0, giving exactly WIDTH steps.
  - FIXUP: apply the sign (negate if the recorded sign is 1), write rsp_result; next state DONE.
  - DONE: rsp_valid=1, and rsp_result / rsp_div_zero are held stable. On rsp_ready, go to IDLE and clear rsp_valid and rsp_div_zero. rsp_result holds its last value.
- Latency (cycle k = accept cycle):
  - ADD/SUB/div-by-zero: rsp_valid first high in cycle k+1.
  - MUL/DIV: rsp_valid first high in cycle k+WIDTH+2.
- Response to a request that stalls in DONE: rsp_ready low holds DONE indefinitely. req_ready stays 0 throughout.
- No same-cycle turnaround: a new request is never accepted in the cycle rsp_ready is taken. The earliest next accept is the following cycle.
- req_valid without req_ready: ignored. The requester must hold the request until accepted. Inputs are sampled only at the accept edge, so later changes to req_a, req_b or req_op do not affect an in-flight op.
- Arithmetic:
  - Signed two's complement; results are computed at full width, so no overflow is possible.
  - -32768*-32768 = 1073741824.
  - -32768 / -1 = 32768.
  - DIV truncates toward zero, matching SystemVerilog signed `/`. The quotient is negative iff the operand signs differ and the quotient is nonzero.
  - MUL result sign = sign(a) XOR sign(b); a zero product is never negated into -0 issues (two's complement).
- Reset mid-operation (ITER/FIXUP/DONE): returns to IDLE the next cycle with all outputs at reset values. The in-flight result is discarded.

Optional Feature:
- Macro CALC_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit). abort high in ITER or FIXUP returns to IDLE at the next edge: no rsp_valid, rsp_result unchanged, req_ready=1 the following cycle.
  - abort in DONE clears rsp_valid and returns to IDLE, dropping the result.
  - abort in IDLE is ignored. When abort and req_valid are both high in IDLE, the request is accepted.
  - rst has priority over abort.
- Undefined: the port does not exist and no abort path is synthesised.

Test Plan:
- Reset mid-MUL:
  - Stimulus: accept MUL 300*200, then assert rst at cycle k+5.
  - Required response: next cycle req_ready=1, rsp_valid=0, busy=0, rsp_result=0. No response ever appears.
- ADD/SUB, rsp_ready tied 1:
  - Stimulus: ADD a=100 b=-250, then SUB a=-32768 b=1.
  - Required response: rsp_result=-150, then -32769. rsp_valid is high exactly in cycle k+1 for each.
- MUL edge values (WIDTH=16):
  - Stimulus: MUL -32768*-32768, then 123*-45.
  - Required response: 1073741824 and -5535, each with rsp_valid first at k+18. busy is high k+1..k+18.
- DIV signs and divide-by-zero:
  - Stimulus: DIV -7/2, 7/-2, -32768/-1, then 5/0.
  - Required response: -3, -3, 32768 with rsp_div_zero=0. For 5/0: result 0 and rsp_div_zero=1 at k+1.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles after MUL 12*12 completes, with req_valid=1 and new operands applied throughout.
  - Required response: rsp_result stays 144 and req_ready stays 0. Once rsp_ready=1, the next request is accepted no earlier than the following cycle.
- Abort, CALC_SEQ_ABORT_EN defined:
  - Stimulus: DIV 1000/7 with abort at k+4.
  - Required response: no rsp_valid and req_ready=1 at k+6. A following ADD 1+1 returns 2.
